// File: rtl/burst_mem_responder.sv
// burst_mem_responder
//   Word-organised memory model for the pipeline's instruction/data port.
//   It accepts one request at a time and serves single-word or burst reads and
//   writes. Reads wait a fixed latency before they start. Data is big-endian:
//   bits [31:24] are the lowest byte address.
//
//   Ports
//     clock        system clock, all state updates on posedge
//     reset        synchronous, active-high
//     address      byte address of first word, bits [1:0] ignored
//     data_in      write data for the current write beat
//     access_size  burst length: 00=1, 01=4, 10=8, 11=16 words
//     rw           1=read, 0=write
//     enable       request strobe, only looked at in IDLE
//     busy         transaction in flight
//     data_out     read data
//     valid        data_out carries a read beat this cycle
//     err          (BURST_MEM_ADDR_CHECK_EN only) one-cycle pulse when a
//                  request falls outside the mapped window
//
//   Optional macro BURST_MEM_ADDR_CHECK_EN: reject out-of-window requests
//   with err. When the macro is not defined, out-of-window addresses fold
//   modulo the array size.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   IDLE         | waiting for enable; single-word writes complete here
//   WAIT         | read accepted, counting down the initial latency
//   READ_BURST   | one read beat on data_out per cycle
//   WRITE_BURST  | one word written from data_in per cycle (beats 1..N-1)
module burst_mem_responder #(
   parameter logic [31:0] base_addr    = 32'h8002_0000,
   parameter int unsigned memory_depth = 1048576,
   parameter int unsigned read_latency = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   input  logic [1:0]  access_size,
   input  logic        rw,
   input  logic        enable,
   output logic        busy,
   output logic [31:0] data_out,
   output logic        valid
`ifdef BURST_MEM_ADDR_CHECK_EN
   ,
   output logic        err
`endif
);

   localparam int unsigned WORDS = memory_depth / 4;
   localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, READ_BURST, WRITE_BURST} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   start_q, start_d;
   logic [4:0]      len_q, len_d;
   logic [4:0]      beat_q, beat_d;
   logic [3:0]      lat_q, lat_d;
   logic            busy_q, busy_d;
   logic            valid_q, valid_d;
   logic [31:0]     data_out_q, data_out_d;

   logic [31:0]     mem_q [WORDS];
   logic            mem_we;
   logic [AW-1:0]   mem_wa;
   logic [31:0]     mem_wd;

   logic [29:0]     word_off;
   logic [AW-1:0]   acc_idx;
   logic [4:0]      acc_len;
   logic [AW-1:0]   cur_idx;
   logic            addr_bad;
   logic            unused_addr_lsb;

   function automatic logic [4:0] burst_len(input logic [1:0] sz);
      case (sz)
         2'b00:   return 5'd1;
         2'b01:   return 5'd4;
         2'b10:   return 5'd8;
         default: return 5'd16;
      endcase
   endfunction

   // start is always < WORDS and off < 16, so one conditional subtract wraps
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base,
                                              input logic [4:0]    off);
      logic [AW:0] sum;
      sum = {1'b0, base} + (AW+1)'(off);
      if (sum >= (AW+1)'(WORDS))
         sum = sum - (AW+1)'(WORDS);
      return sum[AW-1:0];
   endfunction

   assign unused_addr_lsb = ^address[1:0];
   assign word_off = address[31:2] - base_addr[31:2];
   assign acc_idx  = AW'(32'(word_off) % WORDS);
   assign acc_len  = burst_len(access_size);
   assign cur_idx  = wrap_add(start_q, beat_q);

`ifdef BURST_MEM_ADDR_CHECK_EN
   logic [33:0] off_start;
   logic [33:0] off_end;
   logic        err_q, err_d;

   // checking the last byte offset of the burst covers the start word too
   assign off_start = {2'b00, address} - {2'b00, base_addr};
   assign off_end   = off_start + {27'd0, 5'(acc_len - 5'd1), 2'b00};
   assign addr_bad  = (address < base_addr) || (off_end >= 34'(memory_depth));
   assign err       = err_q;
`else
   assign addr_bad  = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      len_d      = len_q;
      beat_d     = beat_q;
      lat_d      = lat_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      data_out_d = data_out_q;
      mem_we     = 1'b0;
      mem_wa     = cur_idx;
      mem_wd     = data_in;
`ifdef BURST_MEM_ADDR_CHECK_EN
      err_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (enable) begin
               if (addr_bad) begin
`ifdef BURST_MEM_ADDR_CHECK_EN
                  err_d = 1'b1;
`endif
               end else begin
                  start_d = acc_idx;
                  len_d   = acc_len;
                  if (rw) begin
                     busy_d = 1'b1;
                     if (read_latency == 0) begin
                        state_d    = READ_BURST;
                        valid_d    = 1'b1;
                        data_out_d = mem_q[acc_idx];
                        beat_d     = 5'd1;
                     end else begin
                        state_d = WAIT;
                        lat_d   = 4'(read_latency - 1);
                        beat_d  = 5'd0;
                     end
                  end else begin
                     // beat 0 is written on the acceptance edge
                     mem_we = 1'b1;
                     mem_wa = acc_idx;
                     if (acc_len != 5'd1) begin
                        state_d = WRITE_BURST;
                        busy_d  = 1'b1;
                        beat_d  = 5'd1;
                     end
                  end
               end
            end
         end
         WAIT: begin
            if (lat_q == 4'd0) begin
               state_d    = READ_BURST;
               valid_d    = 1'b1;
               data_out_d = mem_q[start_q];
               beat_d     = 5'd1;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         READ_BURST: begin
            if (beat_q == len_q) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               beat_d  = 5'd0;
            end else begin
               valid_d    = 1'b1;
               data_out_d = mem_q[cur_idx];
               beat_d     = beat_q + 5'd1;
            end
         end
         WRITE_BURST: begin
            mem_we = 1'b1;
            if (beat_q == 5'(len_q - 5'd1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               beat_d  = 5'd0;
            end else begin
               beat_d = beat_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         start_q    <= '0;
         len_q      <= 5'd0;
         beat_q     <= 5'd0;
         lat_q      <= 4'd0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         data_out_q <= 32'd0;
`ifdef BURST_MEM_ADDR_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         len_q      <= len_d;
         beat_q     <= beat_d;
         lat_q      <= lat_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         data_out_q <= data_out_d;
`ifdef BURST_MEM_ADDR_CHECK_EN
         err_q      <= err_d;
`endif
      end
   end

   // array is not cleared by reset, but a write landing on a reset edge is dropped
   always_ff @(posedge clock) begin
      if (mem_we && !reset)
         mem_q[mem_wa] <= mem_wd;
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign data_out = data_out_q;

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Memory-side responder for the pipeline's instruction and data memory interface (address, data_in, access_size, rw, enable, busy, data_out).
- Serves single-word and burst reads and writes with a configurable initial latency.
- Drives busy while a transaction is in flight, then streams one word per cycle.
- Replaces the zero-latency memory model so that fetch and the memory stage are exercised against real stalls.

Parameters:
- base_addr, 32'h80020000, byte address that maps to array index 0.
- memory_depth, 1048576, array size in bytes; must be a multiple of 4.
- read_latency, 2, wait cycles between acceptance and the first read beat (0..15).

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- address  input  32  byte address; bits [1:0] ignored (word-aligned).
- data_in  input  32  write data, big-endian (bits [31:24] stored at the lowest byte).
- access_size  input  2  burst length: 00=1, 01=4, 10=8, 11=16 words.
- rw  input  1  1=read, 0=write.
- enable  input  1  request strobe; sampled only in IDLE.
- busy  output  1  high from the cycle after acceptance until the last beat has completed.
- data_out  output  32  read data, big-endian.
- valid  output  1  high for exactly the cycles in which data_out carries a read beat.

Behaviour:
- Reset:
  - State becomes IDLE; busy=0, valid=0, data_out=0; beat counter and latency counter are cleared.
  - Array contents are not cleared.
  - A reset asserted mid-transaction aborts it the same cycle. Writes already committed remain; no further beats are issued.
- States are IDLE, WAIT, READ_BURST and WRITE_BURST.
- IDLE:
  - With enable=1 at a posedge, the block latches the word address ((address-base_addr)>>2), the beat count N from access_size, and rw.
  - Read with read_latency>0 goes to WAIT. Read with read_latency=0 goes to READ_BURST.
  - Write goes to WRITE_BURST and writes data_in of the acceptance cycle as beat 0.
- WAIT: counts read_latency cycles with busy=1 and valid=0, then goes to READ_BURST.
- READ_BURST:
  - Each cycle: valid=1 and data_out = word at (start+beat); beat increments.
  - After beat N-1, returns to IDLE with busy=0 and valid=0 in the following cycle.
  - Single-word read latency is read_latency+1 cycles from acceptance to valid.
- WRITE_BURST:
  - One word per cycle from data_in at consecutive word addresses.
  - busy stays high until N words are written, then the block returns to IDLE.
  - Total busy cycles for a write are N-1 (0 for a single word).
  - A single-word write leaves busy low throughout.
- enable while busy=1 is ignored; the block does not queue requests.
- enable may be re-asserted in the first IDLE cycle after a transaction and is accepted there (back-to-back).
- Burst address increment wraps modulo memory_depth/4 words.
- Addresses outside [base_addr, base_addr+memory_depth) fold modulo memory_depth.
- rw and access_size changes during a transaction are ignored; the latched values rule.

Optional Feature:
- Macro: BURST_MEM_ADDR_CHECK_EN.
- When defined, an extra output port err (1 bit) is added.
  - On acceptance of a request whose start or end word lies outside the mapped window: no array access occurs.
  - err=1 for exactly one cycle, in the cycle after acceptance; busy stays 0; the block remains in IDLE.
  - Reset value of err is 0.
- When undefined: no err port, and out-of-window addresses fold modulo memory_depth as described above.

Test Plan:
- Reset, then single read: preload word 0x27BDFFF8 at 0x80020000; read_latency=2; read with access_size=00.
  - Required: busy=1 for 3 cycles; valid=1 exactly once, on the 3rd cycle after acceptance, with data_out=0x27BDFFF8.
- 4-word write burst at 0x80020010 with data 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Then a 4-word read of the same address.
  - Required: valid for 4 consecutive cycles with the same values in order; byte at 0x80020010 is 0x11.
- 16-word read starting at the last word of the window (base_addr+memory_depth-4).
  - Required (feature off): beat 1 returns the word at base_addr.
  - Required (feature on): err pulses once, no valid, busy stays 0.
- Assert enable with a different address while busy during an 8-word read.
  - Required: the request is ignored, all 8 beats come from the original address, then a new request is accepted in the first IDLE cycle.
- Assert reset on beat 2 of an 8-word write.
  - Required: beats 0-1 are stored; beats 2-7 are not written; busy=0 and valid=0 in the next cycle.
- read_latency=0 single read.
  - Required: valid=1 in the cycle after acceptance, and busy=1 for that one cycle only.
